// File: rtl/lfsr_fill_core_if.sv
// Control, readout and status signals of the pattern-fill memory core.
// The bench drives the master side; the core implements the slave side.
interface lfsr_fill_core_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 11
);
   logic              en;
   logic              start;
   logic [ADDR_W-1:0] addr;
   logic              rd_en;
   logic [WIDTH-1:0]  dout;
   logic              dout_valid;
   logic              busy;
   logic              done;

   modport master (
      output en, start, addr, rd_en,
      input  dout, dout_valid, busy, done
   );

   modport slave (
      input  en, start, addr, rd_en,
      output dout, dout_valid, busy, done
   );
endinterface

// File: rtl/lfsr_fill_core.sv
// Fills an internal memory with a counter or LFSR pattern, then serves
// single-cycle-latency reads while not filling.
//
//  state | meaning
//  IDLE  | after reset, waiting for start; reads allowed
//  FILL  | one word written per enabled cycle; reads and start ignored
//  DONE  | whole memory written; reads allowed, start restarts the fill
module lfsr_fill_core #(
   parameter int          WIDTH  = 8,
   parameter int          ADDR_W = 11,
   parameter int          MODE   = 1,
   parameter logic [15:0] SEED   = 16'h0001
) (
   input  logic             clk,
   input  logic             rst_n,
   lfsr_fill_core_if.slave  bus
);
   localparam int          DEPTH    = 2 ** ADDR_W;
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic [15:0]       lfsr, lfsr_nxt;
   logic              lfsr_fb;
   logic              wr_en;
   logic              rd_ok;
   logic [WIDTH-1:0]  pattern;
   logic [WIDTH-1:0]  mem [DEPTH];

   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   generate
      if (MODE == 0) begin : g_counter
         assign pattern = WIDTH'(ptr);
      end else begin : g_lfsr
         assign pattern = lfsr[WIDTH-1:0];
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      lfsr_nxt  = lfsr;
      wr_en     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_nxt = FILL;
               ptr_nxt   = '0;
               lfsr_nxt  = SEED_EFF;
            end
         end
         FILL: begin
            if (bus.en) begin
               wr_en    = 1'b1;
               ptr_nxt  = ptr + ADDR_W'(1);
               lfsr_nxt = {lfsr[14:0], lfsr_fb};
               if (&ptr) state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reads are blocked during FILL, so a read can never collide with a write.
   assign rd_ok = bus.rd_en && (state != FILL);

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state          <= IDLE;
         ptr            <= '0;
         lfsr           <= SEED_EFF;
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
      end else begin
         state          <= state_nxt;
         ptr            <= ptr_nxt;
         lfsr           <= lfsr_nxt;
         bus.dout_valid <= rd_ok;
         if (rd_ok) bus.dout <= mem[bus.addr];
      end
   end

   // Memory is deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (wr_en && !rst_n) mem[ptr] <= pattern;
   end

   assign bus.busy = (state == FILL);
   assign bus.done = (state == DONE);
endmodule

// File: doc/lfsr_fill_core.md
LFSR_FILL_CORE -- requirements
Module: lfsr_fill_core

Parameters
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 1..16.
REQ-002 Parameter ADDR_W, default 11: address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter MODE, default 1: 0 = counter pattern, 1 = LFSR pattern.
REQ-004 Parameter SEED, default 16'h0001: initial LFSR state; SEED = 0 is replaced by 16'hACE1.

Interface
REQ-005 clk  input  1: single clock; all logic on the rising edge.
REQ-006 rst_n  input  1: synchronous active-high reset; asserted = 1 despite the name.
REQ-007 en  input  1: fill enable; 0 pauses the fill without losing state.
REQ-008 start  input  1: single-cycle fill request.
REQ-009 addr  input  ADDR_W: readout address.
REQ-010 rd_en  input  1: readout request.
REQ-011 dout  output  WIDTH: read data.
REQ-012 dout_valid  output  1: high for one cycle when dout is updated.
REQ-013 busy  output  1: high while in FILL.
REQ-014 done  output  1: high while in DONE.

Function
REQ-015 Internal DEPTH x WIDTH memory; FSM states IDLE, FILL, DONE.
REQ-016 IDLE to FILL on start=1: fill pointer = 0, LFSR = SEED (or 16'hACE1).
REQ-017 In FILL with en=1:
- mem[ptr] <= pattern
- ptr increments by 1
- LFSR advances
- exactly one word per cycle.
REQ-018 In FILL with en=0: no write; ptr and LFSR hold.
REQ-019 Pattern, MODE=0: ptr[WIDTH-1:0], zero-extended when WIDTH > ADDR_W.
REQ-020 Pattern, MODE=1: LFSR[WIDTH-1:0].
REQ-021 LFSR: 16-bit Fibonacci. fb = s[15]^s[13]^s[12]^s[10]; next = {s[14:0], fb}.
REQ-022 FILL to DONE on the cycle after the write to address DEPTH-1; total = DEPTH enabled cycles.
REQ-023 busy = 1 exactly in FILL; done = 1 exactly in DONE.
REQ-024 start in FILL is ignored.
REQ-025 start in DONE re-enters FILL with ptr = 0 and LFSR re-seeded (restart).
REQ-026 Readout:
- rd_en=1 in IDLE or DONE gives dout = mem[addr] and dout_valid = 1 on the next cycle (latency 1).
- Otherwise dout_valid = 0 and dout holds its last value.
REQ-027 rd_en in FILL is ignored; dout_valid stays 0 and dout holds.
REQ-028 Same-cycle rd_en and start in IDLE or DONE: the read is serviced from pre-fill contents, and FILL begins on the next cycle.
REQ-029 addr is sampled only in the cycle rd_en=1; back-to-back reads give one result per cycle.
REQ-030 Same-address read and write cannot occur, because reads are blocked in FILL.

Reset
REQ-031 rst_n=1 at a clock edge forces:
- state IDLE, ptr = 0, LFSR = SEED
- dout = 0, dout_valid = 0, busy = 0, done = 0.
REQ-032 Reset has priority over start, en and rd_en.
REQ-033 Memory contents are not cleared by reset; they are undefined until the first completed fill.
REQ-034 Reset mid-FILL aborts the fill: next state is IDLE, done = 0, and the partially written memory stays as is.

Verification
REQ-035 MODE=0, WIDTH=8, ADDR_W=4; start with en=1 held -> busy for 16 cycles, then done=1; reading addr 0..15 returns 00..0F, each dout_valid one cycle after its rd_en.
REQ-036 MODE=1, SEED=16'h0001, WIDTH=16, ADDR_W=4; full fill, then read addr 0, 1, 2, 10, 11 -> 0001, 0002, 0004, 0400, 0801.
REQ-037 Pause case:
- MODE=0, ADDR_W=4; en=0 for 5 cycles mid-fill.
- Required: busy lasts 21 cycles; contents are identical to REQ-035; no address is skipped or duplicated.
REQ-038 Reset mid-fill: rst_n=1 at ptr=7 -> next cycle busy=0, done=0, dout_valid=0; a new start completes a normal fill.
REQ-039 Blocked and restart cases:
- rd_en during FILL -> dout_valid stays 0.
- start in DONE -> busy=1 next cycle, ptr restarts at 0, and the LFSR sequence repeats from the seed.
REQ-040 start asserted together with rd_en addr=3 in DONE -> dout = old mem[3] with dout_valid=1 next cycle; busy=1 the same next cycle.
